pe_multibank: RTL and testbench

Parametrised systolic processing element: the next generation of the array PE, with real multiply-accumulate, selectable integer SIMD modes and `DEPTH` independent accumulator banks for pipelined tiles. It sits in the systolic array alongside other PEs. Operands `a` and `b`, plus per-beat command fields, enter from the left and above and are forwarded one cycle later to the right and below. Accumulated results are drained on a per-PE result port.

---
 rtl/para_pkg.sv | 24 ++
 rtl/pe_dot_unit.sv | 45 ++++
 rtl/pe_multibank.sv | 149 ++++++++++++++
 tb/tb_pe_multibank.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/para_pkg.sv
// rtl/para_pkg.sv - shared op/mode types and lane widths for the systolic PE family
package params;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_INIT  = 2'd1,
        OP_MAC   = 2'd2,
        OP_DRAIN = 2'd3
    } pe_op_t;

    typedef enum logic [1:0] {
        MODE_INT8  = 2'd0,
        MODE_INT16 = 2'd1,
        MODE_INT32 = 2'd2,
        MODE_RSVD  = 2'd3
    } pe_mode_t;

    localparam int WORD_W   = 32;
    localparam int LANE8_W  = 8;
    localparam int LANE16_W = 16;
    localparam int LANES8   = WORD_W / LANE8_W;
    localparam int LANES16  = WORD_W / LANE16_W;

endpackage

// File: rtl/pe_dot_unit.sv
// rtl/pe_dot_unit.sv - combinational mode-selected signed dot product
//
// Ports:
//   a_i, b_i : 32-bit operands, split into signed lanes according to mode_i
//   mode_i   : INT8 (4 byte lanes), INT16 (2 halfword lanes), INT32, RSVD
//   d_o      : sum of lane products, modulo 2^32 (0 for RSVD)
module pe_dot_unit
    import params::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  pe_mode_t    mode_i,
    output logic [31:0] d_o
);

    logic signed [15:0] p8  [LANES8];
    logic signed [31:0] p16 [LANES16];
    logic        [31:0] sum8;
    logic        [31:0] sum16;

    always_comb begin
        sum8  = '0;
        sum16 = '0;
        for (int i = 0; i < LANES8; i++) begin
            p8[i] = $signed(a_i[i*LANE8_W +: LANE8_W]) * $signed(b_i[i*LANE8_W +: LANE8_W]);
            sum8  = sum8 + {{16{p8[i][15]}}, p8[i]};
        end
        for (int i = 0; i < LANES16; i++) begin
            p16[i] = $signed(a_i[i*LANE16_W +: LANE16_W]) * $signed(b_i[i*LANE16_W +: LANE16_W]);
            sum16  = sum16 + p16[i];
        end
    end

    always_comb begin
        d_o = '0;
        case (mode_i)
            MODE_INT8:  d_o = sum8;
            MODE_INT16: d_o = sum16;
            // Low half of the product is identical for signed and unsigned operands.
            MODE_INT32: d_o = a_i * b_i;
            default:    d_o = '0;
        endcase
    end

endmodule

// File: rtl/pe_multibank.sv
// rtl/pe_multibank.sv - systolic PE with multi-bank accumulators and SIMD dot product
//
// Ports:
//   clk, rst                   : clock, synchronous active-low reset
//   en_left/en_right           : horizontal beat valid and its forwarded copy
//   en_up/en_down              : b valid and its forwarded copy
//   op/mode/idx/a/c _left      : per-beat command and operands, forwarded to *_right
//   b_up/b_down                : b operand and its forwarded copy
//   sum_out, sum_valid         : drained accumulator value, one-cycle qualifier
//   err                        : sticky protocol error
module pe_multibank
    import params::*;
#(
    parameter int DEPTH = 4,
    parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_left,
    output logic          en_right,
    input  logic          en_up,
    output logic          en_down,
    input  pe_op_t        op_left,
    output pe_op_t        op_right,
    input  pe_mode_t      mode_left,
    output pe_mode_t      mode_right,
    input  logic [IW-1:0] idx_left,
    output logic [IW-1:0] idx_right,
    input  logic [31:0]   a_left,
    output logic [31:0]   a_right,
    input  logic [31:0]   c_left,
    output logic [31:0]   c_right,
    input  logic [31:0]   b_up,
    output logic [31:0]   b_down,
    output logic [31:0]   sum_out,
    output logic          sum_valid,
    output logic          err
);

    localparam logic [IW:0] DEPTH_W = (IW+1)'(DEPTH);

    logic          en_right_q, en_down_q;
    pe_op_t        op_q;
    pe_mode_t      mode_q;
    logic [IW-1:0] idx_q;
    logic [31:0]   a_q, c_q, b_q;
    logic [31:0]   sum_q, sum_d;
    logic          sum_valid_q, sum_valid_d;
    logic          err_q, err_d;
    logic [31:0]   acc_q [DEPTH];

    logic [31:0]   dot;
    logic          idx_ok, is_arith, illegal, exec;
    logic [31:0]   acc_rd;
    logic          acc_wr;
    logic [31:0]   acc_wr_data;

    pe_dot_unit u_dot (
        .a_i    (a_left),
        .b_i    (b_up),
        .mode_i (mode_left),
        .d_o    (dot)
    );

    always_comb begin
        idx_ok   = {1'b0, idx_left} < DEPTH_W;
        is_arith = (op_left == OP_INIT) || (op_left == OP_MAC);
        // An out-of-range bank is illegal for every op, including NOP and DRAIN.
        illegal  = en_left && (!idx_ok ||
                               (is_arith && (!en_up || mode_left == MODE_RSVD)));
        exec     = en_left && !illegal;

        acc_rd = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (idx_left == IW'(k)) acc_rd = acc_q[k];
        end

        acc_wr      = 1'b0;
        acc_wr_data = '0;
        sum_valid_d = 1'b0;
        sum_d       = sum_q;
        case (op_left)
            OP_INIT: begin
                acc_wr      = exec;
                acc_wr_data = c_left + dot;
            end
            OP_MAC: begin
                acc_wr      = exec;
                acc_wr_data = acc_rd + dot;
            end
            OP_DRAIN: begin
                acc_wr      = exec;
                acc_wr_data = '0;
                sum_valid_d = exec;
                sum_d       = exec ? acc_rd : sum_q;
            end
            default: ;
        endcase

        err_d = err_q | illegal;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            en_right_q  <= 1'b0;
            en_down_q   <= 1'b0;
            op_q        <= OP_NOP;
            mode_q      <= MODE_INT8;
            idx_q       <= '0;
            a_q         <= '0;
            c_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            err_q       <= 1'b0;
            for (int k = 0; k < DEPTH; k++) acc_q[k] <= '0;
        end else begin
            en_right_q <= en_left;
            en_down_q  <= en_up;
            if (en_left) begin
                op_q   <= op_left;
                mode_q <= mode_left;
                idx_q  <= idx_left;
                a_q    <= a_left;
                c_q    <= c_left;
            end
            if (en_up) b_q <= b_up;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            err_q       <= err_d;
            for (int k = 0; k < DEPTH; k++) begin
                if (acc_wr && idx_left == IW'(k)) acc_q[k] <= acc_wr_data;
            end
        end
    end

    assign en_right   = en_right_q;
    assign en_down    = en_down_q;
    assign op_right   = op_q;
    assign mode_right = mode_q;
    assign idx_right  = idx_q;
    assign a_right    = a_q;
    assign c_right    = c_q;
    assign b_down     = b_q;
    assign sum_out    = sum_q;
    assign sum_valid  = sum_valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_pe_multibank.sv
// tb/tb_pe_multibank.sv - self-checking scoreboard bench for pe_multibank
module tb_pe_multibank;
    import params::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en_left, en_up;
    pe_op_t      op_left;
    pe_mode_t    mode_left;
    logic [1:0]  idx_left;
    logic [31:0] a_left, c_left, b_up;
    logic        en_right, en_down, sum_valid, err;
    pe_op_t      op_right;
    pe_mode_t    mode_right;
    logic [1:0]  idx_right;
    logic [31:0] a_right, c_right, b_down, sum_out;

    pe_multibank #(.DEPTH(4)) u_dut (
        .clk(clk), .rst(rst),
        .en_left(en_left), .en_right(en_right),
        .en_up(en_up), .en_down(en_down),
        .op_left(op_left), .op_right(op_right),
        .mode_left(mode_left), .mode_right(mode_right),
        .idx_left(idx_left), .idx_right(idx_right),
        .a_left(a_left), .a_right(a_right),
        .c_left(c_left), .c_right(c_right),
        .b_up(b_up), .b_down(b_down),
        .sum_out(sum_out), .sum_valid(sum_valid), .err(err)
    );

    logic        en3_left, en3_up;
    pe_op_t      op3_left;
    pe_mode_t    mode3_left;
    logic [1:0]  idx3_left;
    logic [31:0] a3_left, c3_left, b3_up;
    logic        en3_right, en3_down, sum3_valid, err3;
    pe_op_t      op3_right;
    pe_mode_t    mode3_right;
    logic [1:0]  idx3_right;
    logic [31:0] a3_right, c3_right, b3_down, sum3_out;

    pe_multibank #(.DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .en_left(en3_left), .en_right(en3_right),
        .en_up(en3_up), .en_down(en3_down),
        .op_left(op3_left), .op_right(op3_right),
        .mode_left(mode3_left), .mode_right(mode3_right),
        .idx_left(idx3_left), .idx_right(idx3_right),
        .a_left(a3_left), .a_right(a3_right),
        .c_left(c3_left), .c_right(c3_right),
        .b_up(b3_up), .b_down(b3_down),
        .sum_out(sum3_out), .sum_valid(sum3_valid), .err(err3)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model of the DEPTH=4 instance
    logic [31:0] m_acc [4];
    logic [31:0] m_sum;
    logic        m_valid, m_err;
    logic [31:0] f_a, f_c, f_b;
    pe_op_t      f_op;
    pe_mode_t    f_mode;
    logic [1:0]  f_idx;
    logic [31:0] sb_q [$];

    function automatic logic [31:0] dot_ref(input pe_mode_t md, input logic [31:0] a, input logic [31:0] b);
        int s;
        s = 0;
        case (md)
            MODE_INT8:  for (int i = 0; i < 4; i++)
                            s += int'($signed(a[8*i +: 8])) * int'($signed(b[8*i +: 8]));
            MODE_INT16: for (int i = 0; i < 2; i++)
                            s += int'($signed(a[16*i +: 16])) * int'($signed(b[16*i +: 16]));
            MODE_INT32: s = int'(a) * int'(b);
            default:    s = 0;
        endcase
        return 32'(s);
    endfunction

    task automatic step(input logic r, input logic el, input logic eu, input pe_op_t op,
                        input pe_mode_t md, input logic [1:0] idx,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        logic bad;
        rst = r; en_left = el; en_up = eu; op_left = op; mode_left = md;
        idx_left = idx; a_left = a; b_up = b; c_left = c;
        m_valid = 1'b0;
        if (!r) begin
            for (int k = 0; k < 4; k++) m_acc[k] = '0;
            m_sum = '0; m_err = 1'b0;
            f_a = '0; f_c = '0; f_b = '0; f_op = OP_NOP; f_mode = MODE_INT8; f_idx = '0;
        end else begin
            if (el) begin
                f_a = a; f_c = c; f_op = op; f_mode = md; f_idx = idx;
                bad = (op == OP_INIT || op == OP_MAC) && (!eu || md == MODE_RSVD);
                if (bad) m_err = 1'b1;
                else if (op == OP_INIT) m_acc[idx] = c + dot_ref(md, a, b);
                else if (op == OP_MAC)  m_acc[idx] = m_acc[idx] + dot_ref(md, a, b);
                else if (op == OP_DRAIN) begin
                    m_sum = m_acc[idx]; m_valid = 1'b1; m_acc[idx] = '0;
                    sb_q.push_back(m_sum);
                end
            end
            if (eu) f_b = b;
        end
        @(posedge clk);
        #1;
        check_val("sum_valid", {31'd0, sum_valid}, {31'd0, m_valid});
        if (sum_valid) begin
            if (sb_q.size() == 0) check_val("sb_unexpected_pulse", 32'd1, 32'd0);
            else check_val("sb_sum", sum_out, sb_q.pop_front());
        end
        check_val("sum_out_hold", sum_out, m_sum);
        check_val("err", {31'd0, err}, {31'd0, m_err});
        check_val("en_right", {31'd0, en_right}, {31'd0, r & el});
        check_val("en_down", {31'd0, en_down}, {31'd0, r & eu});
        check_val("a_right", a_right, f_a);
        check_val("c_right", c_right, f_c);
        check_val("b_down", b_down, f_b);
        check_val("op_right", {30'd0, op_right}, {30'd0, f_op});
        check_val("mode_right", {30'd0, mode_right}, {30'd0, f_mode});
        check_val("idx_right", {30'd0, idx_right}, {30'd0, f_idx});
    endtask

    task automatic beat(input pe_op_t op, input pe_mode_t md, input logic [1:0] idx,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        step(1'b1, 1'b1, 1'b1, op, md, idx, a, b, c);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, OP_NOP, MODE_INT8, 2'd0, 32'd0, 32'd0, 32'd0);
        check_val("rst_acc_err", {31'd0, err}, 32'd0);
    endtask

    task automatic step3(input pe_op_t op, input pe_mode_t md, input logic [1:0] idx,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic exp_valid, input logic [31:0] exp_sum, input logic exp_err);
        en3_left = 1'b1; en3_up = 1'b1; op3_left = op; mode3_left = md;
        idx3_left = idx; a3_left = a; b3_up = b; c3_left = 32'd0;
        @(posedge clk);
        #1;
        check_val("d3_valid", {31'd0, sum3_valid}, {31'd0, exp_valid});
        if (exp_valid) check_val("d3_sum", sum3_out, exp_sum);
        check_val("d3_err", {31'd0, err3}, {31'd0, exp_err});
    endtask

    initial begin
        en3_left = 1'b0; en3_up = 1'b0; op3_left = OP_NOP; mode3_left = MODE_INT8;
        idx3_left = '0; a3_left = '0; c3_left = '0; b3_up = '0;

        do_reset();
        do_reset();

        // INT8 INIT then double drain
        beat(OP_INIT,  MODE_INT8, 2'd0, 32'h01020304, 32'h01010101, 32'd5);
        beat(OP_DRAIN, MODE_INT8, 2'd0, 32'd0, 32'd0, 32'd0);
        check_val("int8_drain", sum_out, 32'd15);
        beat(OP_DRAIN, MODE_INT8, 2'd0, 32'd0, 32'd0, 32'd0);
        check_val("int8_redrain", sum_out, 32'd0);

        // INT16 MAC x3 on bank 1, back-to-back drains of all banks
        do_reset();
        repeat (3) beat(OP_MAC, MODE_INT16, 2'd1, 32'h0002FFFF, 32'h00030002, 32'd0);
        beat(OP_DRAIN, MODE_INT8, 2'd1, 32'd0, 32'd0, 32'd0);
        check_val("int16_drain", sum_out, 32'd12);
        for (int k = 0; k < 4; k++) beat(OP_DRAIN, MODE_INT8, 2'(k), 32'd0, 32'd0, 32'd0);

        // INT32 wrap cases
        beat(OP_INIT,  MODE_INT32, 2'd2, 32'd1, 32'd1, 32'h7FFFFFFF);
        beat(OP_DRAIN, MODE_INT32, 2'd2, 32'd0, 32'd0, 32'd0);
        check_val("int32_wrap", sum_out, 32'h80000000);
        beat(OP_INIT,  MODE_INT32, 2'd3, 32'hFFFFFFFF, 32'd2, 32'd0);
        beat(OP_DRAIN, MODE_INT32, 2'd3, 32'd0, 32'd0, 32'd0);
        check_val("int32_neg", sum_out, 32'hFFFFFFFE);

        // MAC then DRAIN on the same bank back-to-back
        beat(OP_INIT,  MODE_INT32, 2'd0, 32'd3, 32'd4, 32'd1);
        beat(OP_MAC,   MODE_INT32, 2'd0, 32'd2, 32'd5, 32'd0);
        beat(OP_DRAIN, MODE_INT32, 2'd0, 32'd0, 32'd0, 32'd0);
        check_val("mac_then_drain", sum_out, 32'd23);

        // MAC without b: bank unchanged, err sticky
        beat(OP_INIT, MODE_INT32, 2'd1, 32'd7, 32'd1, 32'd0);
        step(1'b1, 1'b1, 1'b0, OP_MAC, MODE_INT32, 2'd1, 32'd9, 32'd9, 32'd0);
        check_val("mac_noup_err", {31'd0, err}, 32'd1);
        beat(OP_NOP, MODE_INT8, 2'd0, 32'd0, 32'd0, 32'd0);
        beat(OP_DRAIN, MODE_INT8, 2'd1, 32'd0, 32'd0, 32'd0);
        check_val("mac_noup_bank", sum_out, 32'd7);
        check_val("err_sticky", {31'd0, err}, 32'd1);

        // RSVD mode
        do_reset();
        beat(OP_INIT, MODE_INT8, 2'd2, 32'd0, 32'd0, 32'd44);
        beat(OP_MAC,  MODE_RSVD, 2'd2, 32'd5, 32'd5, 32'd0);
        check_val("rsvd_err", {31'd0, err}, 32'd1);
        beat(OP_DRAIN, MODE_INT8, 2'd2, 32'd0, 32'd0, 32'd0);
        check_val("rsvd_bank", sum_out, 32'd44);

        // Random beats, enables toggling
        do_reset();
        for (int i = 0; i < 60; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 pe_op_t'($urandom_range(0, 3)), pe_mode_t'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);

        // Reset mid-stream with a drain in the reset cycle
        do_reset();
        for (int k = 0; k < 4; k++) beat(OP_MAC, MODE_INT32, 2'(k), 32'(k + 2), 32'd3, 32'd0);
        step(1'b0, 1'b1, 1'b1, OP_DRAIN, MODE_INT8, 2'd1, 32'd0, 32'd0, 32'd0);
        check_val("rst_drain_lost", {31'd0, sum_valid}, 32'd0);
        for (int k = 0; k < 4; k++) beat(OP_DRAIN, MODE_INT8, 2'(k), 32'd0, 32'd0, 32'd0);
        check_val("rst_err_clear", {31'd0, err}, 32'd0);

        // DEPTH=3 instance: idx 3 is out of range
        step3(OP_NOP,   MODE_INT8,  2'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        step3(OP_MAC,   MODE_INT32, 2'd2, 32'd6, 32'd7, 1'b0, 32'd0, 1'b0);
        step3(OP_MAC,   MODE_INT32, 2'd3, 32'd1, 32'd1, 1'b0, 32'd0, 1'b1);
        step3(OP_DRAIN, MODE_INT8,  2'd3, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        step3(OP_DRAIN, MODE_INT8,  2'd2, 32'd0, 32'd0, 1'b1, 32'd42, 1'b1);

        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
